// File: rtl/vga_sync_monitor.sv
// vga_sync_monitor: measures incoming VGA sync timing (line period, hsync
// width, lines per frame), tracks line-period stability with a lock FSM and,
// while locked, reports the position and colour of each active pixel.
//
// Output handshake: o_pix_valid qualifies o_pix_x/o_pix_y/o_pix_rgb for
// exactly the cycle it is high; there is no backpressure, and every pix_* bit
// is 0 whenever o_pix_valid is 0.
module vga_sync_monitor #(
    parameter int H_BACK_PORCH = 92,
    parameter int H_DISPLAY    = 1220,
    parameter int V_BACK_PORCH = 33,
    parameter int V_DISPLAY    = 480,
    parameter int LOCK_LINES   = 16    // must fit the 8-bit match counter
) (
    input  logic        i_clk48,
    input  logic        i_rst_n,
    input  logic        i_vsync_n,
    input  logic        i_hsync_n,
    input  logic [2:0]  i_rgb_in,
    output logic        o_locked,
    output logic        o_lost_lock,
    output logic [10:0] o_line_period,
    output logic [7:0]  o_hsync_width,
    output logic [9:0]  o_frame_lines,
    output logic        o_pix_valid,
    output logic [10:0] o_pix_x,
    output logic [9:0]  o_pix_y,
    output logic [2:0]  o_pix_rgb,
    output logic [1:0]  o_dbg_state
);

    typedef enum logic [1:0] {
        ST_SEARCH = 2'd0,
        ST_TRACK  = 2'd1,
        ST_LOCKED = 2'd2
    } state_t;

    localparam logic [10:0] C_HBP  = 11'(H_BACK_PORCH);
    localparam logic [10:0] C_HD   = 11'(H_DISPLAY);
    localparam logic [9:0]  C_VBP  = 10'(V_BACK_PORCH);
    localparam logic [9:0]  C_VD   = 10'(V_DISPLAY);
    localparam logic [7:0]  C_LOCK = 8'(LOCK_LINES);
    localparam logic [10:0] C_HMAX = 11'h7FF;
    localparam logic [9:0]  C_YMAX = 10'h3FF;

    // Synchronizer chains: bit 0 = 1st flop, bit 1 = 2nd (synced), bit 2 = previous.
    logic [2:0]  r_hs_sync;
    logic [2:0]  r_vs_sync;
    logic [2:0]  r_rgb_s1, r_rgb_s2, r_rgb_s3;

    logic [10:0] r_hcnt;
    logic [10:0] r_line_period;
    logic [7:0]  r_hlow_cnt;
    logic [7:0]  r_hsync_width;
    logic [9:0]  r_line_cnt;
    logic [9:0]  r_frame_lines;
    logic [10:0] r_xcnt;
    logic [9:0]  r_ly;

    state_t      r_state;
    logic [11:0] r_ref;
    logic [7:0]  r_match;
    logic        r_lost;

    logic        r_pix_valid;
    logic [10:0] r_pix_x;
    logic [9:0]  r_pix_y;
    logic [2:0]  r_pix_rgb;

    logic        w_hfall, w_hrise, w_vfall, w_vrise;
    logic        w_hsat;
    logic [11:0] w_hper;
    logic [11:0] w_diff;
    logic        w_close;
    logic [9:0]  w_line_inc;
    logic [10:0] w_xoff;
    logic [9:0]  w_yoff;
    logic        w_pix_hit;

    state_t      w_state_nx;
    logic [11:0] w_ref_nx;
    logic [7:0]  w_match_nx;
    logic        w_lost_nx;

    assign w_hfall = r_hs_sync[2] & ~r_hs_sync[1];
    assign w_hrise = ~r_hs_sync[2] & r_hs_sync[1];
    assign w_vfall = r_vs_sync[2] & ~r_vs_sync[1];
    assign w_vrise = ~r_vs_sync[2] & r_vs_sync[1];

    assign w_hsat  = (r_hcnt == C_HMAX);
    assign w_hper  = {1'b0, r_hcnt} + 12'd1;
    assign w_diff  = (w_hper >= r_ref) ? (w_hper - r_ref) : (r_ref - w_hper);
    assign w_close = (w_diff <= 12'd1);

    // A same-cycle hfall belongs to the frame that the vfall closes.
    assign w_line_inc = (w_hfall && r_line_cnt != C_YMAX) ? r_line_cnt + 10'd1 : r_line_cnt;

    assign w_xoff    = r_xcnt - C_HBP;
    assign w_yoff    = r_ly - C_VBP;
    assign w_pix_hit = (r_state == ST_LOCKED) &&
                       (r_xcnt >= C_HBP) && (w_xoff < C_HD) &&
                       (r_ly >= C_VBP) && (w_yoff < C_VD);

    // Input synchronizers; sync flops idle high so reset release makes no edge.
    always_ff @(posedge i_clk48 or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_hs_sync <= 3'b111;
            r_vs_sync <= 3'b111;
            r_rgb_s1  <= 3'b000;
            r_rgb_s2  <= 3'b000;
            r_rgb_s3  <= 3'b000;
        end else begin
            r_hs_sync <= {r_hs_sync[1:0], i_hsync_n};
            r_vs_sync <= {r_vs_sync[1:0], i_vsync_n};
            r_rgb_s1  <= i_rgb_in;
            r_rgb_s2  <= r_rgb_s1;
            r_rgb_s3  <= r_rgb_s2;
        end
    end

    // Timing measurements: line period, hsync low width, lines per frame.
    always_ff @(posedge i_clk48 or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_hcnt        <= 11'd0;
            r_line_period <= 11'd0;
            r_hlow_cnt    <= 8'd0;
            r_hsync_width <= 8'd0;
            r_line_cnt    <= 10'd0;
            r_frame_lines <= 10'd0;
        end else begin
            if (w_hfall) begin
                r_hcnt <= 11'd0;
                if (!w_hsat) r_line_period <= w_hper[10:0];
            end else if (!w_hsat) begin
                r_hcnt <= r_hcnt + 11'd1;
            end

            if (w_hfall) r_hlow_cnt <= 8'd1;
            else if (!r_hs_sync[1] && r_hlow_cnt != 8'hFF) r_hlow_cnt <= r_hlow_cnt + 8'd1;
            if (w_hrise) r_hsync_width <= r_hlow_cnt;

            if (w_vfall) begin
                r_frame_lines <= w_line_inc;
                r_line_cnt    <= 10'd0;
            end else begin
                r_line_cnt    <= w_line_inc;
            end
        end
    end

    // Raster position: column from hsync rise, line from vsync rise.
    always_ff @(posedge i_clk48 or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_xcnt <= 11'd0;
            r_ly   <= 10'd0;
        end else begin
            if (w_hrise) r_xcnt <= 11'd0;
            else if (r_xcnt != C_HMAX) r_xcnt <= r_xcnt + 11'd1;

            if (w_vrise) r_ly <= w_hrise ? 10'd1 : 10'd0;
            else if (w_hrise && r_ly != C_YMAX) r_ly <= r_ly + 10'd1;
        end
    end

    // Lock FSM state register.
    always_ff @(posedge i_clk48 or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_state <= ST_SEARCH;
            r_ref   <= 12'd0;
            r_match <= 8'd0;
            r_lost  <= 1'b0;
        end else begin
            r_state <= w_state_nx;
            r_ref   <= w_ref_nx;
            r_match <= w_match_nx;
            r_lost  <= w_lost_nx;
        end
    end

    // Lock FSM next state: lines within +/-1 clock of the reference count as matches.
    always_comb begin
        w_state_nx = r_state;
        w_ref_nx   = r_ref;
        w_match_nx = r_match;
        w_lost_nx  = 1'b0;
        if (w_hsat) begin
            w_state_nx = ST_SEARCH;
            w_lost_nx  = (r_state == ST_LOCKED);
        end else begin
            case (r_state)
                ST_SEARCH: begin
                    if (w_hfall) begin
                        w_ref_nx   = w_hper;
                        w_match_nx = 8'd0;
                        w_state_nx = ST_TRACK;
                    end
                end
                ST_TRACK: begin
                    if (w_hfall) begin
                        if (w_close) begin
                            if (r_match < C_LOCK) w_match_nx = r_match + 8'd1;
                        end else begin
                            w_ref_nx   = w_hper;
                            w_match_nx = 8'd0;
                        end
                    end
                    if (w_vfall && w_match_nx >= C_LOCK) w_state_nx = ST_LOCKED;
                end
                ST_LOCKED: begin
                    if (w_hfall && !w_close) begin
                        w_state_nx = ST_SEARCH;
                        w_lost_nx  = 1'b1;
                    end
                end
                default: w_state_nx = ST_SEARCH;
            endcase
        end
    end

    // Registered pixel report; all fields forced to 0 outside the active window.
    always_ff @(posedge i_clk48 or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_pix_valid <= 1'b0;
            r_pix_x     <= 11'd0;
            r_pix_y     <= 10'd0;
            r_pix_rgb   <= 3'd0;
        end else begin
            r_pix_valid <= w_pix_hit;
            r_pix_x     <= w_pix_hit ? w_xoff : 11'd0;
            r_pix_y     <= w_pix_hit ? w_yoff : 10'd0;
            r_pix_rgb   <= w_pix_hit ? r_rgb_s3 : 3'd0;
        end
    end

    assign o_locked      = (r_state == ST_LOCKED);
    assign o_lost_lock   = r_lost;
    assign o_line_period = r_line_period;
    assign o_hsync_width = r_hsync_width;
    assign o_frame_lines = r_frame_lines;
    assign o_pix_valid   = r_pix_valid;
    assign o_pix_x       = r_pix_x;
    assign o_pix_y       = r_pix_y;
    assign o_pix_rgb     = r_pix_rgb;
    assign o_dbg_state   = r_state;

endmodule

// File: tb/tb_vga_sync_monitor.sv
// Bench for vga_sync_monitor using a scaled-down raster (40-clock lines,
// 12-line frames) so several lock/unlock scenarios fit in a short run.
module tb_vga_sync_monitor;

  localparam int HBP   = 6;
  localparam int HD    = 20;
  localparam int VBP   = 3;
  localparam int VD    = 5;
  localparam int LOCKN = 4;

  localparam int PER   = 40;
  localparam int LOW   = 6;
  localparam int NL    = 12;

  logic        clk48 = 1'b0;
  logic        rst_n;
  logic        vsync_n;
  logic        hsync_n;
  logic [2:0]  rgb_in;
  logic        locked;
  logic        lost_lock;
  logic [10:0] line_period;
  logic [7:0]  hsync_width;
  logic [9:0]  frame_lines;
  logic        pix_valid;
  logic [10:0] pix_x;
  logic [9:0]  pix_y;
  logic [2:0]  pix_rgb;
  logic [1:0]  dbg_state;

  int total = 0;
  int bad = 0;
  int lost_cnt = 0;

  logic [23:0] exp_q[$];

  vga_sync_monitor #(
    .H_BACK_PORCH(HBP),
    .H_DISPLAY(HD),
    .V_BACK_PORCH(VBP),
    .V_DISPLAY(VD),
    .LOCK_LINES(LOCKN)
  ) dut (
    .i_clk48(clk48),
    .i_rst_n(rst_n),
    .i_vsync_n(vsync_n),
    .i_hsync_n(hsync_n),
    .i_rgb_in(rgb_in),
    .o_locked(locked),
    .o_lost_lock(lost_lock),
    .o_line_period(line_period),
    .o_hsync_width(hsync_width),
    .o_frame_lines(frame_lines),
    .o_pix_valid(pix_valid),
    .o_pix_x(pix_x),
    .o_pix_y(pix_y),
    .o_pix_rgb(pix_rgb),
    .o_dbg_state(dbg_state)
  );

  // clock / reset
  always #5 clk48 = ~clk48;

  // scoreboard monitor: pops one expected pixel per reported pixel
  always @(negedge clk48) begin
    logic [23:0] exp;
    if (lost_lock) begin
      lost_cnt++;
      total++;
      if (locked !== 1'b0) begin
        bad++;
        $display("FAIL lost_with_locked: got locked=%b required 0", locked);
      end
    end
    if (pix_valid) begin
      total++;
      if (exp_q.size() == 0) begin
        bad++;
        $display("FAIL pixel_unexpected: got x=%0d y=%0d rgb=%b required no pixel", pix_x, pix_y, pix_rgb);
      end else begin
        exp = exp_q.pop_front();
        if ({pix_x, pix_y, pix_rgb} !== exp) begin
          bad++;
          $display("FAIL pixel: got x=%0d y=%0d rgb=%b required x=%0d y=%0d rgb=%b",
                   pix_x, pix_y, pix_rgb, exp[23:13], exp[12:3], exp[2:0]);
        end
      end
    end else begin
      total++;
      if ({pix_x, pix_y, pix_rgb} !== 24'd0) begin
        bad++;
        $display("FAIL pixel_idle_zero: got x=%0d y=%0d rgb=%b required all 0", pix_x, pix_y, pix_rgb);
      end
    end
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0d required %0d", name, act, exp);
    end
  endtask

  task automatic check_zero(input string tag);
    check({tag, "_locked"}, 32'(locked), 0);
    check({tag, "_lost_lock"}, 32'(lost_lock), 0);
    check({tag, "_line_period"}, 32'(line_period), 0);
    check({tag, "_hsync_width"}, 32'(hsync_width), 0);
    check({tag, "_frame_lines"}, 32'(frame_lines), 0);
    check({tag, "_pix_valid"}, 32'(pix_valid), 0);
    check({tag, "_pix_x"}, 32'(pix_x), 0);
    check({tag, "_pix_y"}, 32'(pix_y), 0);
    check({tag, "_pix_rgb"}, 32'(pix_rgb), 0);
    check({tag, "_state"}, 32'(dbg_state), 0);
  endtask

  // driver: one line of 'steps' clocks, hsync low for the first 'low' clocks.
  // Pattern mode puts the pixel column (mod 8) on rgb_in, aligned to hsync rise.
  task automatic drive_line(input int steps, input int low, input logic vs,
                            input bit pat, input bit push, input int y);
    if (push) begin
      for (int x = 0; x < HD; x++) begin
        exp_q.push_back({11'(x), 10'(y), pat ? 3'(x) : 3'b101});
      end
    end
    for (int c = 0; c < steps; c++) begin
      @(negedge clk48);
      hsync_n = (c < low) ? 1'b0 : 1'b1;
      vsync_n = vs;
      rgb_in  = pat ? 3'(c - low - HBP) : 3'b101;
    end
  endtask

  // driver: frame of nlines lines, vsync low for lines 0 and 1.
  // Active lines are VBP+1 .. VBP+VD; pixels are expected up to push_last.
  task automatic drive_frame(input int nlines, input int per, input int low, input bit pat,
                             input bit jitter, input int stretch_line, input int push_last);
    for (int l = 0; l < nlines; l++) begin
      int steps;
      bit push;
      steps = per;
      if (jitter) steps = (l % 2 == 0) ? per - 1 : per + 1;
      if (l == stretch_line) steps = per + 4;
      push = (l >= VBP + 1) && (l <= VBP + VD) && (l <= push_last);
      drive_line(steps, low, (l < 2) ? 1'b0 : 1'b1, pat, push, l - 1 - VBP);
    end
  endtask

  initial begin
    rst_n   = 1'b0;
    hsync_n = 1'b1;
    vsync_n = 1'b1;
    rgb_in  = 3'b000;
    repeat (3) @(negedge clk48);
    check_zero("reset");
    rst_n = 1'b1;
    repeat (5) @(negedge clk48);

    // first frame after reset: tracking only
    drive_frame(NL, PER, LOW, 1'b0, 1'b0, -1, -1);
    check("f1_locked", 32'(locked), 0);
    check("f1_line_period", 32'(line_period), PER);
    check("f1_hsync_width", 32'(hsync_width), LOW);
    check("f1_frame_lines", 32'(frame_lines), 1);

    // second vfall locks; constant colour pixels
    drive_frame(NL, PER, LOW, 1'b0, 1'b0, -1, 99);
    check("f2_locked", 32'(locked), 1);
    check("f2_frame_lines", 32'(frame_lines), NL);

    // colour pattern checks pixel/colour alignment
    drive_frame(NL, PER, LOW, 1'b1, 1'b0, -1, 99);
    check("f3_locked", 32'(locked), 1);

    // +/-1 jitter keeps lock
    drive_frame(NL, PER, LOW, 1'b0, 1'b1, -1, 99);
    check("jit_locked", 32'(locked), 1);
    check("jit_lost_cnt", 32'(lost_cnt), 0);
    check("jit_line_period", 32'(line_period), PER - 1);
    check("jit_frame_lines", 32'(frame_lines), NL);

    // line 5 stretched: lock lost at the hfall ending it
    drive_frame(NL, PER, LOW, 1'b0, 1'b0, 5, 5);
    check("str_locked", 32'(locked), 0);
    check("str_lost_cnt", 32'(lost_cnt), 1);
    check("str_state", 32'(dbg_state), 1);
    check("str_line_period", 32'(line_period), PER);

    // relock at the next vfall
    drive_frame(NL, PER, LOW, 1'b1, 1'b0, -1, 99);
    check("relock_locked", 32'(locked), 1);

    // reset mid-line during an active line
    drive_frame(4, PER, LOW, 1'b0, 1'b0, -1, 99);
    drive_line(20, LOW, 1'b1, 1'b0, 1'b1, 0);
    @(negedge clk48);
    rst_n   = 1'b0;
    hsync_n = 1'b1;
    vsync_n = 1'b1;
    #1;
    check_zero("midreset");
    exp_q.delete();
    repeat (3) @(negedge clk48);
    rst_n = 1'b1;
    repeat (8) @(negedge clk48);
    check_zero("release");

    // measurements discarded: full lock sequence needed again
    drive_frame(NL, PER, LOW, 1'b0, 1'b0, -1, -1);
    check("rA_locked", 32'(locked), 0);
    drive_frame(NL, PER, LOW, 1'b0, 1'b0, -1, 99);
    check("rB_locked", 32'(locked), 1);

    // hsync stuck high: hcnt saturates, lock dropped, period kept
    drive_line(3000, 0, 1'b1, 1'b0, 1'b0, 0);
    check("stuck_locked", 32'(locked), 0);
    check("stuck_state", 32'(dbg_state), 0);
    check("stuck_lost_cnt", 32'(lost_cnt), 2);
    check("stuck_line_period", 32'(line_period), PER);

    // hfall while saturated: no period update; long low saturates width
    drive_line(340, 300, 1'b1, 1'b0, 1'b0, 0);
    check("sat_line_period", 32'(line_period), PER);
    check("sat_hsync_width", 32'(hsync_width), 255);
    check("sat_state", 32'(dbg_state), 0);

    // nominal line timing
    for (int i = 0; i < 3; i++) drive_line(1526, 183, 1'b1, 1'b0, 1'b0, 0);
    check("nom_line_period", 32'(line_period), 1526);
    check("nom_hsync_width", 32'(hsync_width), 183);
    check("nom_state", 32'(dbg_state), 1);

    // line counting: 525 lines, then saturation at 1023
    drive_frame(525, 6, 3, 1'b0, 1'b0, -1, -1);
    drive_frame(1100, 6, 3, 1'b0, 1'b0, -1, -1);
    check("fl_525", 32'(frame_lines), 525);
    drive_frame(2, 6, 3, 1'b0, 1'b0, -1, -1);
    check("fl_sat", 32'(frame_lines), 1023);
    check("fl_locked", 32'(locked), 1);

    repeat (4) @(negedge clk48);
    check("pixels_pending", 32'(exp_q.size()), 0);
    check("final_lost_cnt", 32'(lost_cnt), 2);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/vga_sync_monitor.md
VGA_SYNC_MONITOR -- requirements
Module: vga_sync_monitor

Interface
REQ-001 Parameters (name, default, meaning), one per line:
- H_BACK_PORCH, 92, clocks from hsync rising edge to first active pixel
- H_DISPLAY, 1220, active pixels per line
- V_BACK_PORCH, 33, hsync rising edges from vsync rising edge to active line 0
- V_DISPLAY, 480, active lines per frame
- LOCK_LINES, 16, consecutive matching lines required before lock
REQ-002 Ports (name, direction, width, meaning), one per line:
- clk48, in, 1, pixel clock
- rst_n, in, 1, asynchronous active-low reset
- vsync_n, in, 1, active-low vsync
- hsync_n, in, 1, active-low hsync
- rgb_in, in, 3, {R,G,B} 1-bit colour
- locked, out, 1, timing lock achieved
- lost_lock, out, 1, one-cycle pulse on LOCKED to SEARCH
- line_period, out, 11, clocks between last two hsync falling edges
- hsync_width, out, 8, clocks hsync was last low
- frame_lines, out, 10, hsync falling edges between last two vsync falling edges
- pix_valid, out, 1, pix_* describe an active pixel
- pix_x, out, 11, active pixel column
- pix_y, out, 10, active pixel row
- pix_rgb, out, 3, captured colour

Function
REQ-003 All five inputs SHALL pass a 2-flop synchronizer; a third flop SHALL provide the previous value for edge detection.
REQ-004 Edge events (hfall, hrise, vfall, vrise) SHALL be combinational compares of 2nd vs 3rd flop; pix_* outputs SHALL be registered, giving 4 clk48 edges from input pin to pix_*.
REQ-005 hcnt (11 b) SHALL count clocks since the last hfall and saturate at 2047. On hfall: line_period <= hcnt+1 and hcnt <= 0, unless hcnt is saturated, in which case line_period is not updated.
REQ-006 hsync_width SHALL count clocks while synced hsync_n = 0, saturate at 255, and latch on hrise.
REQ-007 frame_lines SHALL count hfall events (saturating at 1023), latch on vfall, then clear; hfall and vfall in the same cycle SHALL count that hfall in the closing frame.
REQ-008 xcnt (11 b) SHALL clear to 0 on hrise and otherwise increment, saturating at 2047. ly (10 b) SHALL clear to 0 on vrise and increment on hrise, saturating at 1023. vrise and hrise in the same cycle SHALL give ly = 1.
REQ-009 Active-pixel window: pix_valid = locked && (xcnt - H_BACK_PORCH) in [0, H_DISPLAY) && (ly - V_BACK_PORCH) in [0, V_DISPLAY), all compares unsigned with no wrap. Then pix_x = xcnt - H_BACK_PORCH, pix_y = ly - V_BACK_PORCH, pix_rgb = synced rgb_in. Otherwise pix_x, pix_y and pix_rgb SHALL be 0.
REQ-010 The lock FSM SHALL have three states: SEARCH, TRACK, LOCKED.
- SEARCH: on a valid hfall (hcnt not saturated), ref <= hcnt+1, match <= 0, go to TRACK.
- TRACK: on each hfall, if |hcnt+1 - ref| <= 1 then match++ (saturating at LOCK_LINES); else ref <= hcnt+1, match <= 0, stay in TRACK. Go to LOCKED on the first vfall with match >= LOCK_LINES.
- LOCKED: an hfall with |hcnt+1 - ref| > 1, or hcnt reaching 2047, SHALL go to SEARCH and pulse lost_lock for 1 cycle.
- Any state: hcnt saturation SHALL force SEARCH.
REQ-011 locked SHALL be 1 iff state = LOCKED, registered, with no extra delay.

Reset
REQ-012 rst_n low SHALL immediately clear the FSM to SEARCH, clear all counters and all outputs to 0, and preset synchronizer flops for vsync_n/hsync_n to 1 so that release does not produce a false edge.
REQ-013 Reset asserted mid-frame SHALL discard all measurements; relock SHALL require LOCK_LINES full matching lines plus a vfall.

Verification
REQ-014 Nominal 1526x525 timing (hsync low 183 clocks, vsync low 2 lines): line_period = 1526, hsync_width = 183, frame_lines = 525; locked rises at the 2nd vfall after reset.
REQ-015 Locked, rgb_in = 3'b101 constant: pix_valid high for exactly 1220 clocks per line and 480 lines per frame; first pixel pix_x = 0, pix_y = 0, pix_rgb = 101; last pixel pix_x = 1219, pix_y = 479.
REQ-016 Locked, one line stretched to 1530 clocks: lost_lock pulses 1 cycle at that hfall, locked = 0, and relock occurs at the first vfall after 16 matching lines.
REQ-017 hsync_n held high for 3000 clocks: SEARCH entered when hcnt hits 2047; line_period keeps its previous value.
REQ-018 Line jitter of 1525/1527 alternating: lock is held and lost_lock stays 0.
REQ-019 rst_n pulsed low mid-line while locked: all outputs read 0 within the same cycle; no edge event occurs on release with hsync_n = 1.
